// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder slice, LSB-first
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             slice_sum;
   logic             slice_carry;
   logic             last_bit;
   logic [WIDTH-1:0] res_next;

   assign slice_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign slice_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
   assign last_bit    = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_bit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
   always_comb begin
      res_next            = res_sh_q >> 1;
      res_next[WIDTH-1]   = slice_sum;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               res_sh_d = '0;
               carry_d  = cin;
               cnt_d    = '0;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_next;
            carry_d  = slice_carry;
            cnt_d    = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d  = res_next;
               cout_d = slice_carry;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
      sum  = sum_q;
      cout = cout_q;
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and sweep checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b;
   logic       cin;
   logic       busy, done, cout;
   logic [7:0] sum;

   logic       start1, a1, b1, cin1;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One WIDTH=8 add; operands are scrambled during RUN to prove they were captured.
   task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic [8:0] exp);
      int         lat;
      int         nbusy;
      logic [8:0] prev;
      logic       held;
      prev = {cout, sum};
      held = 1'b1;
      @(negedge clk);
      a = ta; b = tb; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 40) begin
         if (busy) nbusy++;
         if ({cout, sum} !== prev) held = 1'b0;
         a = ~a; b = 8'($urandom); cin = ~cin;
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, 9);
      check({tag, " busy_cycles"}, nbusy, 8);
      check({tag, " held_in_run"}, held, 1);
      check({tag, " result"}, {cout, sum}, exp);
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      int         lat;
      int         ndone;
      int         t1, cyc;
      logic [7:0] ra, rb;
      logic       rc;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum_cout", {cout, sum}, 0);
      check("reset w1 outputs", {busy1, done1, cout1, sum1}, 0);
      rst_n = 1'b1;

      run8("t1 5A+33", 8'h5A, 8'h33, 1'b0, 9'h08D);
      run8("t2 FF+01", 8'hFF, 8'h01, 1'b0, 9'h100);
      run8("t2 FF+FF+1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

      // start pulse in RUN cycle 3 must be ignored
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; a = 8'h80;
      @(negedge clk); start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 14; i++) begin
         if (done) begin
            ndone++;
            check("t3 result", {cout, sum}, 9'h002);
            check("t3 latency", i + 4, 9);
         end
         @(negedge clk);
      end
      check("t3 done_count", ndone, 1);

      // reset mid-RUN
      @(negedge clk);
      a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("t4 busy_before_reset", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t4 busy", busy, 0);
      check("t4 done", done, 0);
      check("t4 sum_cout", {cout, sum}, 0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      check("t4 no_activity", ndone, 0);

      // start held high, two operand sets
      a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
      cyc = 0; t1 = -1; ndone = 0;
      while (ndone < 2 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               t1 = cyc;
               check("t5 first_result", {cout, sum}, 9'h047);
               a = 8'hA0; b = 8'h70; cin = 1'b0;
            end else begin
               check("t5 spacing", cyc - t1, 10);
               check("t5 second_result", {cout, sum}, 9'h110);
               start = 1'b0;
            end
         end
      end
      check("t5 done_pulses", ndone, 2);
      repeat (3) @(negedge clk);

      // WIDTH=1 instance
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      check("t6 w1 busy", busy1, 1);
      lat = 1;
      while (!done1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("t6 w1 latency", lat, 2);
      check("t6 w1 result", {cout1, sum1}, 2'b11);
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("t6 w1 result2", {cout1, sum1}, 2'b01);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         run8($sformatf("sweep%0d", i), ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
